// File: rtl/mdu_sequencer_pkg.sv
// Shared constants for the E-stage multiply/divide unit: MDU op codes,
// sequencer state encodings and a small op-classification helper.
// Imported by mdu_sequencer.
package mdu_sequencer_pkg;

   // MDU op codes carried on e_mdu_op
   localparam logic [2:0] MDU_NOP   = 3'd0;
   localparam logic [2:0] MDU_MULT  = 3'd1;
   localparam logic [2:0] MDU_MULTU = 3'd2;
   localparam logic [2:0] MDU_DIV   = 3'd3;
   localparam logic [2:0] MDU_DIVU  = 3'd4;
   localparam logic [2:0] MDU_MTHI  = 3'd5;
   localparam logic [2:0] MDU_MTLO  = 3'd6;

   // Sequencer state encodings
   localparam logic [0:0] MDU_S_IDLE = 1'b0;
   localparam logic [0:0] MDU_S_BUSY = 1'b1;

   // True for the ops that launch a multi-cycle operation
   function automatic logic is_start_op(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Purpose: E-stage multiply/divide unit with HI/LO; MULT/MULTU/DIV/DIVU, MTHI/MTLO.
// Latency: result computed at the start edge, committed to hi/lo after MULT_CYCLES/DIV_CYCLES busy cycles.
// Backpressure: mdu_stall holds MDU-related D-stage instructions while a start is in E or busy is high.
//
// Ports: clk/reset (async active-high); e_mdu_op, e_mdu_start, e_rs, e_rt from E stage;
//   req flushes the E-stage instruction; d_mdu_related qualifies the stall;
//   busy, mdu_stall, hi, lo outputs.
// Build option: MDU_DIV0_HOLD_EN -- divide by zero leaves hi/lo unchanged at commit
//   (default: lo=0xFFFFFFFF, hi=dividend).
module mdu_sequencer
   import mdu_sequencer_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  e_mdu_op,
   input  logic        e_mdu_start,
   input  logic [31:0] e_rs,
   input  logic [31:0] e_rt,
   input  logic        req,
   input  logic        d_mdu_related,
   output logic        busy,
   output logic        mdu_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      pending_hi, pending_lo;

   // ---------------- arithmetic (operands from E stage) ----------------
   logic        is_signed, is_mul, div_zero, a_neg, b_neg;
   logic [63:0] mul_a, mul_b, prod;
   logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quo, rem;
   logic [31:0] res_hi, res_lo;

   always_comb begin
      is_signed = (e_mdu_op == MDU_MULT) || (e_mdu_op == MDU_DIV);
      is_mul    = (e_mdu_op == MDU_MULT) || (e_mdu_op == MDU_MULTU);

      // Sign-extending both operands to 64 bits makes the low 64 bits of an
      // unsigned product equal to the signed product.
      mul_a = {{32{is_signed & e_rs[31]}}, e_rs};
      mul_b = {{32{is_signed & e_rt[31]}}, e_rt};
      prod  = mul_a * mul_b;

      // Divide on magnitudes, then restore signs: quotient negative when
      // operand signs differ, remainder follows the dividend.
      a_neg    = is_signed & e_rs[31];
      b_neg    = is_signed & e_rt[31];
      mag_a    = a_neg ? (~e_rs + 32'd1) : e_rs;
      mag_b    = b_neg ? (~e_rt + 32'd1) : e_rt;
      div_zero = (e_rt == 32'd0);
      div_b    = div_zero ? 32'd1 : mag_b;   // keeps the divider well-defined
      q_mag    = mag_a / div_b;
      r_mag    = mag_a % div_b;
      // 0x80000000 / -1 lands here with no negation and yields 0x80000000.
      quo      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

      if (is_mul) begin
         res_hi = prod[63:32];
         res_lo = prod[31:0];
      end else if (div_zero) begin
`ifdef MDU_DIV0_HOLD_EN
         // hi/lo cannot change while busy, so capturing them now preserves them.
         res_hi = hi;
         res_lo = lo;
`else
         res_hi = e_rs;
         res_lo = 32'hFFFF_FFFF;
`endif
      end else begin
         res_hi = rem;
         res_lo = quo;
      end
   end

   // ---------------- sequencer ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= MDU_S_IDLE;
         cnt        <= '0;
         hi         <= 32'd0;
         lo         <= 32'd0;
         pending_hi <= 32'd0;
         pending_lo <= 32'd0;
      end else begin
         case (state)
            MDU_S_IDLE: begin
               if (e_mdu_start && !req && is_start_op(e_mdu_op)) begin
                  pending_hi <= res_hi;
                  pending_lo <= res_lo;
                  cnt        <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  state      <= MDU_S_BUSY;
               end else if (!req && e_mdu_op == MDU_MTHI) begin
                  hi <= e_rs;
               end else if (!req && e_mdu_op == MDU_MTLO) begin
                  lo <= e_rs;
               end
            end
            MDU_S_BUSY: begin
               // Starts and MTHI/MTLO are ignored here; req does not cancel an
               // operation that was already issued.
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  hi    <= pending_hi;
                  lo    <= pending_lo;
                  state <= MDU_S_IDLE;
               end
            end
            default: state <= MDU_S_IDLE;
         endcase
      end
   end

   assign busy      = (state == MDU_S_BUSY);
   assign mdu_stall = d_mdu_related & (e_mdu_start | busy);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: a table of single-operation vectors with
// expected busy length and hi/lo, then hand-written stall, busy-interference
// and mid-operation reset sequences.
module tb_mdu_sequencer;
   import mdu_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  e_mdu_op;
   logic        e_mdu_start;
   logic [31:0] e_rs, e_rt;
   logic        req;
   logic        d_mdu_related;
   logic        busy, mdu_stall;
   logic [31:0] hi, lo;

   int n_vec  = 0;
   int n_fail = 0;

   mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk           (clk),
      .reset         (reset),
      .e_mdu_op      (e_mdu_op),
      .e_mdu_start   (e_mdu_start),
      .e_rs          (e_rs),
      .e_rt          (e_rt),
      .req           (req),
      .d_mdu_related (d_mdu_related),
      .busy          (busy),
      .mdu_stall     (mdu_stall),
      .hi            (hi),
      .lo            (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic        start;
      logic        rq;
      logic [31:0] rs;
      logic [31:0] rt;
      int          exp_cyc;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic [2:0] op, input logic st, input logic rq,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input int cyc, input logic [31:0] eh, input logic [31:0] el);
      vec_t v;
      v.op = op; v.start = st; v.rq = rq; v.rs = rs; v.rt = rt;
      v.exp_cyc = cyc; v.exp_hi = eh; v.exp_lo = el;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      e_mdu_op = MDU_NOP; e_mdu_start = 1'b0; req = 1'b0;
      e_rs = 32'd0; e_rt = 32'd0;
   endtask

   // Starting an operation while busy is illegal upstream.
   always @(negedge clk) begin
      if (!reset && busy && e_mdu_start) begin
         n_fail++;
         $display("FAIL protocol: start asserted while busy");
      end
   end

   initial begin
      int n;

      // Expected values are chained: each vector starts from the previous hi/lo.
      vecs[0]  = mk(MDU_MULT,  1, 0, 32'd3,        32'hFFFFFFFE, 5,  32'hFFFFFFFF, 32'hFFFFFFFA);
      vecs[1]  = mk(MDU_DIV,   1, 0, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      vecs[2]  = mk(MDU_DIVU,  1, 0, 32'd7,        32'd2,        10, 32'd1,        32'd3);
      vecs[3]  = mk(MDU_MULTU, 1, 1, 32'd5,        32'd5,        0,  32'd1,        32'd3);
      vecs[4]  = mk(MDU_MTLO,  0, 1, 32'h1234,     32'd0,        0,  32'd1,        32'd3);
      vecs[5]  = mk(MDU_MTHI,  0, 0, 32'hABCD,     32'd0,        0,  32'hABCD,     32'd3);
      vecs[6]  = mk(MDU_MTLO,  0, 0, 32'h1234,     32'd0,        0,  32'hABCD,     32'h1234);
      vecs[7]  = mk(MDU_MULTU, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
      vecs[8]  = mk(MDU_MULT,  1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001);
      vecs[9]  = mk(MDU_DIV,   1, 0, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
      vecs[10] = mk(MDU_DIV,   1, 0, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
`ifdef MDU_DIV0_HOLD_EN
      vecs[11] = mk(MDU_DIVU,  1, 0, 32'd9,        32'd0,        10, 32'h00000001, 32'hFFFFFFFD);
      vecs[12] = mk(MDU_DIV,   1, 0, 32'hFFFFFFF9, 32'd0,        10, 32'h00000001, 32'hFFFFFFFD);
`else
      vecs[11] = mk(MDU_DIVU,  1, 0, 32'd9,        32'd0,        10, 32'h00000009, 32'hFFFFFFFF);
      vecs[12] = mk(MDU_DIV,   1, 0, 32'hFFFFFFF9, 32'd0,        10, 32'hFFFFFFF9, 32'hFFFFFFFF);
`endif
      vecs[13] = mk(MDU_MULTU, 1, 0, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000);
      vecs[14] = mk(MDU_NOP,   0, 0, 32'hDEADBEEF, 32'd1,        0,  32'h00000001, 32'h00000000);

      // ---- reset state ----
      reset = 1'b1; d_mdu_related = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("reset busy",  {31'd0, busy},      32'd0);
      check("reset stall", {31'd0, mdu_stall}, 32'd0);
      check("reset hi",    hi, 32'd0);
      check("reset lo",    lo, 32'd0);
      reset = 1'b0; d_mdu_related = 1'b0;
      tick();

      // ---- table-driven single operations ----
      for (int i = 0; i < NV; i++) begin
         e_mdu_op = vecs[i].op; e_mdu_start = vecs[i].start; req = vecs[i].rq;
         e_rs = vecs[i].rs; e_rt = vecs[i].rt;
         tick();
         idle_inputs();
         n = 0;
         while (busy && n < 100) begin
            n++;
            tick();
         end
         check($sformatf("vec%0d busy_cycles", i), 32'(n), 32'(vecs[i].exp_cyc));
         check($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
         check($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
      end

      // ---- MTHI and req during busy: ignored / operation still commits ----
      e_mdu_op = MDU_MULT; e_mdu_start = 1'b1; e_rs = 32'd7; e_rt = 32'd6;
      tick();
      idle_inputs();
      n = 0;
      while (busy && n < 100) begin
         e_mdu_op = MDU_MTHI; e_rs = 32'hDEAD;
         req = (n != 0);
         n++;
         tick();
      end
      idle_inputs();
      check("busy_interfere cycles", 32'(n), 32'd5);
      check("busy_interfere hi", hi, 32'd0);
      check("busy_interfere lo", lo, 32'h2A);

      // ---- stall during start and busy cycles, MTHI right after ----
      d_mdu_related = 1'b1;
      e_mdu_op = MDU_MULT; e_mdu_start = 1'b1; e_rs = 32'd2; e_rt = 32'd3;
      #1;
      check("stall start_cycle", {31'd0, mdu_stall}, 32'd1);
      tick();
      idle_inputs();
      n = 0;
      while (busy && n < 100) begin
         check($sformatf("stall busy%0d", n), {31'd0, mdu_stall}, 32'd1);
         n++;
         tick();
      end
      check("stall busy_cycles", 32'(n), 32'd5);
      check("stall after", {31'd0, mdu_stall}, 32'd0);
      check("stall mult lo", lo, 32'd6);
      d_mdu_related = 1'b0;
      e_mdu_op = MDU_MTHI; e_rs = 32'hABCD;
      tick();
      idle_inputs();
      check("mthi after hi", hi, 32'hABCD);

      // ---- async reset in the third busy cycle of a DIVU ----
      e_mdu_op = MDU_DIVU; e_mdu_start = 1'b1; e_rs = 32'd100; e_rt = 32'd7;
      tick();
      idle_inputs();
      tick();
      tick();
      check("pre_reset busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset hi", hi, 32'd0);
      check("midreset lo", lo, 32'd0);
      #2 reset = 1'b0;
      repeat (15) tick();
      check("postreset busy", {31'd0, busy}, 32'd0);
      check("postreset hi", hi, 32'd0);
      check("postreset lo", lo, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
